// File: rtl/fifo_rd_downsizer.sv
// fifo_rd_downsizer: drains words from a synchronous FIFO (empty/data/pop)
// and emits each word as RATIO narrower beats on a valid/ready stream.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   flush_i            synchronous flush, drops the held word
//   fifo_empty_i       FIFO empty flag
//   fifo_data_i        FIFO head word (valid while fifo_empty_i=0)
//   fifo_pop_o         pop the FIFO head this cycle
//   out_valid_o        output beat valid
//   out_data_o         output beat
//   out_last_o         final beat of the current word
//   out_ready_i        consumer accepts the beat
//   busy_o             a word is held
//   words_cnt_o        (FIFO_RD_DOWNSIZER_STATS_EN) count of FIFO pops
//   stall_cnt_o        (FIFO_RD_DOWNSIZER_STATS_EN) count of stalled cycles
//
// Optional feature macro: FIFO_RD_DOWNSIZER_STATS_EN adds the two counters.
module fifo_rd_downsizer #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 8,
  parameter bit          LSB_FIRST = 1'b1,
  parameter int unsigned RATIO     = IN_WIDTH / OUT_WIDTH,
  parameter int unsigned CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 fifo_empty_i,
  input  logic [IN_WIDTH-1:0]  fifo_data_i,
  output logic                 fifo_pop_o,
  output logic                 out_valid_o,
  output logic [OUT_WIDTH-1:0] out_data_o,
  output logic                 out_last_o,
  input  logic                 out_ready_i,
  output logic                 busy_o
`ifdef FIFO_RD_DOWNSIZER_STATS_EN
  ,
  output logic [31:0]          words_cnt_o,
  output logic [31:0]          stall_cnt_o
`endif
);

  if (IN_WIDTH % OUT_WIDTH != 0) begin : g_bad_width
    $error("fifo_rd_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH");
  end

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [IN_WIDTH-1:0]  word_q, word_d;
  logic [CNT_W-1:0]     beat_q, beat_d;
  logic                 pop_c;
  logic                 handshake_c;
  logic                 last_beat_c;

  // Beat order is resolved at elaboration: slice[k] is the k-th beat sent.
  logic [OUT_WIDTH-1:0] slice [RATIO];
  for (genvar i = 0; i < RATIO; i++) begin : g_slice
    localparam int unsigned LO = LSB_FIRST ? i * OUT_WIDTH
                                           : (RATIO - 1 - i) * OUT_WIDTH;
    assign slice[i] = word_q[LO +: OUT_WIDTH];
  end

  assign out_valid_o = (state_q == SEND);
  assign busy_o      = out_valid_o;
  assign out_data_o  = slice[beat_q];
  assign last_beat_c = (beat_q == LAST_BEAT);
  assign out_last_o  = out_valid_o & last_beat_c;
  assign handshake_c = out_valid_o & out_ready_i;
  // Pop is combinational so the next word loads on the last handshake edge.
  assign fifo_pop_o  = pop_c & rst_ni;

  // Next-state and pop decision; flush overrides everything else.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    beat_d  = beat_q;
    pop_c   = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
      beat_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (!fifo_empty_i) begin
            pop_c   = 1'b1;
            word_d  = fifo_data_i;
            beat_d  = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          if (handshake_c) begin
            if (!last_beat_c) begin
              beat_d = beat_q + CNT_W'(1);
            end else if (!fifo_empty_i) begin
              pop_c  = 1'b1;
              word_d = fifo_data_i;
              beat_d = '0;
            end else begin
              state_d = EMPTY;
              beat_d  = '0;
            end
          end
        end
        default: begin
          state_d = EMPTY;
          beat_d  = '0;
        end
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      word_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      beat_q  <= beat_d;
    end
  end

`ifdef FIFO_RD_DOWNSIZER_STATS_EN
  logic [31:0] words_cnt_q, words_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Event counters; a flush cycle clears them and its own events are dropped.
  always_comb begin
    words_cnt_d = words_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_i) begin
      words_cnt_d = '0;
      stall_cnt_d = '0;
    end else begin
      if (pop_c) words_cnt_d = words_cnt_q + 32'd1;
      if (out_valid_o && !out_ready_i) stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      words_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      words_cnt_q <= words_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign words_cnt_o = words_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

`ifndef SYNTHESIS
  a_pop_not_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    fifo_pop_o |-> !fifo_empty_i);
  a_valid_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_valid_o && !out_ready_i && !flush_i) |=> $stable(out_data_o));
`endif

endmodule

// File: doc/fifo_rd_downsizer.md
Name: fifo_rd_downsizer

Overview:
- Read-side companion to the team's synchronous FIFO.
- Drains FIFO words through the FIFO's empty/data/pop interface.
- Emits each word as RATIO narrower beats on a valid/ready stream.
- Target use: splitting 32-bit fetch/peripheral words into byte or halfword beats for narrow consumers (UART TX, 16-bit aligners).

Parameters:
- IN_WIDTH, 32: FIFO word width.
- OUT_WIDTH, 8: output beat width. IN_WIDTH % OUT_WIDTH must be 0; elaboration error otherwise.
- LSB_FIRST, 1: 1 = beat 0 is bits [OUT_WIDTH-1:0]; 0 = beat 0 is the most significant slice.
- RATIO, IN_WIDTH/OUT_WIDTH: derived; do not override.
- CNT_W, (RATIO>1)?$clog2(RATIO):1: derived beat-counter width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active-low.
- flush_i  in  1  synchronous flush; discards the held word.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_data_i  in  IN_WIDTH  FIFO head data; valid whenever fifo_empty_i=0.
- fifo_pop_o  out  1  pop the FIFO head this cycle.
- out_valid_o  out  1  output beat valid.
- out_data_o  out  OUT_WIDTH  output beat.
- out_last_o  out  1  current beat is the final beat of its word.
- out_ready_i  in  1  consumer accepts the beat.
- busy_o  out  1  a word is held (state SEND).

Behaviour:
- Registers:
  - state_q: EMPTY or SEND.
  - word_q [IN_WIDTH].
  - beat_q [CNT_W].
- Reset: state_q=EMPTY, word_q=0, beat_q=0. Resulting outputs: out_valid_o=0, out_last_o=0, busy_o=0, out_data_o=0. fifo_pop_o is forced 0 while rst_ni=0.
- out_valid_o = busy_o = (state_q==SEND).
- out_data_o: slice beat_q of word_q (from the low end if LSB_FIRST, else from the high end). Still driven from word_q when not valid.
- out_last_o = out_valid_o & (beat_q==RATIO-1).
- EMPTY state:
  - fifo_pop_o = ~fifo_empty_i.
  - On pop: word_q<=fifo_data_i, beat_q<=0, state_q<=SEND.
- SEND state, handshake = out_valid_o & out_ready_i:
  - No handshake: all registers hold; out_data_o stable (AXI-style valid stability).
  - Handshake with beat_q<RATIO-1: beat_q<=beat_q+1.
  - Handshake with beat_q==RATIO-1 and fifo_empty_i=0: fifo_pop_o=1, word_q<=fifo_data_i, beat_q<=0, stay in SEND. No bubble between words.
  - Handshake with beat_q==RATIO-1 and fifo_empty_i=1: state_q<=EMPTY, beat_q<=0.
- fifo_pop_o is 0 in every case not listed above. It never asserts while fifo_empty_i=1.
- Latency:
  - First beat is valid the cycle after fifo_empty_i first reads 0.
  - Sustained throughput is 1 beat/cycle with out_ready_i held high.
- RATIO==1: every beat is last; the block acts as a one-entry registered pop stage, throughput 1 word/cycle.
- flush_i (priority over all other updates):
  - state_q<=EMPTY, beat_q<=0; word_q is not updated.
  - fifo_pop_o=0 that cycle.
  - Any handshake in that cycle is void; the consumer must drop it.
  - flush_i is asserted together with the FIFO's flush_i.
- Asynchronous reset mid-word: the partial word is lost; outputs return to reset values immediately.
- Assertions (simulation only, not in SYNTHESIS):
  - fifo_pop_o |-> ~fifo_empty_i.
  - out_valid_o & ~out_ready_i |=> $stable(out_data_o) unless flush_i.

Optional Feature:
- Macro: FIFO_RD_DOWNSIZER_STATS_EN.
- Defined:
  - Adds output words_cnt_o[31:0]: increments on every fifo_pop_o.
  - Adds output stall_cnt_o[31:0]: increments each cycle with out_valid_o & ~out_ready_i.
  - Both counters wrap 0xFFFF_FFFF -> 0 and clear on reset and on flush_i.
  - On a flush_i cycle the counters read 0 next cycle; that cycle's events are not counted.
- Undefined: both ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Basic order, LSB_FIRST=1, OUT_WIDTH=8: FIFO holds 0xA1B2C3D4, out_ready_i=1 -> beats 0xD4,0xC3,0xB2,0xA1 on 4 consecutive cycles; out_last_o only on 0xA1; then EMPTY, busy_o=0.
- Back-to-back: words 0x11223344, 0x55667788, ready=1 -> 8 beats in 8 consecutive cycles; second pop coincides with the 0x11 handshake; no idle cycle.
- Backpressure: ready=0 for 3 cycles on beat 1 of 0xDEADBEEF -> 0xBE held stable, no pop, beat_q unchanged; with STATS_EN, stall_cnt_o=3.
- LSB_FIRST=0, OUT_WIDTH=16: word 0xCAFEF00D -> beats 0xCAFE then 0xF00D (last).
- Flush mid-word: flush_i on beat 2 of 0x01020304 with FIFO holding 0x0A0B0C0D -> next cycle out_valid_o=0, no pop during flush; the following cycle pops again; with FIFO also flushed, the FIFO reads empty and the block stays EMPTY.
- Reset mid-word: rst_ni low during beat 1 -> out_valid_o=0 and fifo_pop_o=0 immediately; after release with FIFO holding 0x99887766, beats restart at 0x66.
